// File: rtl/sample_decimator_pkg.sv
// Shared sample type, default width and FIFO level sizing for the sample decimator.
package sample_pkg;

    localparam int DW_DEFAULT = 16;

    typedef logic signed [DW_DEFAULT-1:0] sample_t;

    function automatic int level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sample_decimator_if.sv
// Sample in/out handshake bundle between the FIR stage, the decimator and the DAC side.
interface sample_decimator_if
    import sample_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int FIFO_DEPTH = 8
);

    localparam int LW = level_w(FIFO_DEPTH);

    logic [DW-1:0] data_i;
    logic          valid_i;
    logic [DW-1:0] data_o;
    logic          valid_o;
    logic          ready_i;
    logic [LW-1:0] level_o;
    logic          overflow_o;

    modport master (
        output data_i, valid_i, ready_i,
        input  data_o, valid_o, level_o, overflow_o
    );

    modport slave (
        input  data_i, valid_i, ready_i,
        output data_o, valid_o, level_o, overflow_o
    );

endinterface

// File: rtl/sample_decimator_sync_fifo.sv
// First-word-fall-through synchronous FIFO; push is accepted when full if a pop happens in the same cycle.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       pop_data,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Extra pointer MSB tells full (MSBs differ) from empty (pointers equal).
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop   = pop && !empty;
    assign do_push  = push && (!full || do_pop);
    assign level    = wr_ptr - rd_ptr;
    assign pop_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/sample_decimator.sv
// Keeps one sample in FACTOR and queues it for the DAC side.
// Define DECIMATOR_AVG_EN to emit the floor average of each group instead of its last sample.
module sample_decimator
    import sample_pkg::*;
#(
    parameter int DW         = DW_DEFAULT,
    parameter int FACTOR     = 4,
    parameter int FIFO_DEPTH = 8
) (
    input logic               clock,
    input logic               reset,
    sample_decimator_if.slave bus
);

    localparam int PW = (FACTOR > 1) ? $clog2(FACTOR) : 1;

    logic          rst_meta;
    logic          rst_sync;
    logic [PW-1:0] phase;
    logic          emit;
    logic [DW-1:0] emit_data;
    logic          pop;
    logic          fifo_full;
    logic          fifo_empty;
    logic          overflow;

    // Reset asserts immediately but is released in step with the clock.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) {rst_sync, rst_meta} <= 2'b00;
        else        {rst_sync, rst_meta} <= {rst_meta, 1'b1};
    end

    assign emit = bus.valid_i && (phase == PW'(FACTOR - 1));
    assign pop  = bus.valid_o && bus.ready_i;

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync)        phase <= '0;
        else if (bus.valid_i) phase <= emit ? '0 : phase + PW'(1);
    end

`ifdef DECIMATOR_AVG_EN
    localparam int SH = $clog2(FACTOR);
    localparam int AW = DW + SH;

    logic signed [AW-1:0] acc;
    logic signed [AW-1:0] sum;

    // Phase 0 starts a fresh group, so the running sum is replaced rather than extended.
    always_comb begin
        sum = AW'($signed(bus.data_i));
        if (phase != '0) sum = acc + AW'($signed(bus.data_i));
    end

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync)        acc <= '0;
        else if (bus.valid_i) acc <= sum;
    end

    assign emit_data = DW'(sum >>> SH);
`else
    assign emit_data = bus.data_i;
`endif

    always_ff @(posedge clock or negedge rst_sync) begin
        if (!rst_sync)                        overflow <= 1'b0;
        else if (emit && fifo_full && !pop)   overflow <= 1'b1;
    end

    sync_fifo #(
        .WIDTH (DW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock     (clock),
        .reset     (rst_sync),
        .push      (emit),
        .push_data (emit_data),
        .pop       (pop),
        .pop_data  (bus.data_o),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .level     (bus.level_o)
    );

    assign bus.valid_o    = !fifo_empty;
    assign bus.overflow_o = overflow;

endmodule

// File: tb/tb_sample_decimator.sv
// Directed, table-driven bench for sample_decimator (FACTOR=4, FIFO_DEPTH=8); expectations follow DECIMATOR_AVG_EN.
module tb_sample_decimator;
    import sample_pkg::*;

    localparam int DW     = 16;
    localparam int FACTOR = 4;
    localparam int DEPTH  = 8;

    typedef struct {
        logic       valid;
        sample_t    data;
        logic       ready;
        logic       exp_valid;
        sample_t    exp_data;
        logic [3:0] exp_level;
    } vec_t;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    always #5 clock = ~clock;

    sample_decimator_if #(.DW(DW), .FIFO_DEPTH(DEPTH)) bus ();

    sample_decimator #(
        .DW         (DW),
        .FACTOR     (FACTOR),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check_num(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic check_data(input string name, input sample_t actual, input sample_t expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic apply_stimulus(input logic valid, input sample_t data, input logic ready);
        bus.valid_i = valid;
        bus.data_i  = data;
        bus.ready_i = ready;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset();
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b0;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
    endtask

    task automatic fill_groups(input int groups);
        for (int k = 0; k < groups; k++)
            for (int j = 0; j < FACTOR; j++)
                apply_stimulus(1'b1, sample_t'(10 * (k + 1)), 1'b0);
    endtask

    initial begin
        vec_t    t1 [12];
        sample_t e1 [3];
        sample_t e2 [2];
        sample_t g5 [3][4];
        sample_t e5 [3];
        logic    exp_v;

`ifdef DECIMATOR_AVG_EN
        e1 = '{sample_t'(1), sample_t'(5), sample_t'(9)};
        e2 = '{sample_t'(101), sample_t'(105)};
        e5 = '{sample_t'(-32768), sample_t'(-1), sample_t'(32767)};
`else
        e1 = '{sample_t'(3), sample_t'(7), sample_t'(11)};
        e2 = '{sample_t'(103), sample_t'(107)};
        e5 = '{sample_t'(-32768), sample_t'(0), sample_t'(32767)};
`endif
        g5[0] = '{sample_t'(-32768), sample_t'(-32768), sample_t'(-32768), sample_t'(-32768)};
        g5[1] = '{sample_t'(-1), sample_t'(-1), sample_t'(-1), sample_t'(0)};
        g5[2] = '{sample_t'(32767), sample_t'(32767), sample_t'(32767), sample_t'(32767)};

        for (int i = 0; i < 12; i++) begin
            t1[i].valid     = 1'b1;
            t1[i].data      = sample_t'(i);
            t1[i].ready     = 1'b1;
            t1[i].exp_valid = (i % 4 == 3);
            t1[i].exp_data  = (i % 4 == 3) ? e1[i / 4] : sample_t'(0);
            t1[i].exp_level = (i % 4 == 3) ? 4'd1 : 4'd0;
        end

        bus.valid_i = 1'b0;
        bus.data_i  = '0;
        bus.ready_i = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_num("reset_valid", 32'(bus.valid_o), 0);
        check_num("reset_data", 32'(bus.data_o), 0);
        check_num("reset_level", 32'(bus.level_o), 0);
        check_num("reset_overflow", 32'(bus.overflow_o), 0);
        reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;

        $display("[TB] continuous strobes 0..11");
        for (int i = 0; i < 12; i++) begin
            apply_stimulus(t1[i].valid, t1[i].data, t1[i].ready);
            check_num($sformatf("t1_valid_%0d", i), 32'(bus.valid_o), 32'(t1[i].exp_valid));
            check_num($sformatf("t1_level_%0d", i), 32'(bus.level_o), 32'(t1[i].exp_level));
            if (t1[i].exp_valid)
                check_data($sformatf("t1_data_%0d", i), sample_t'(bus.data_o), t1[i].exp_data);
        end

        $display("[TB] strobe every third cycle");
        for (int s = 0; s < 8; s++) begin
            for (int c = 0; c < 3; c++) begin
                apply_stimulus(c == 0, sample_t'(100 + s), 1'b1);
                exp_v = (c == 0) && (s % 4 == 3);
                check_num($sformatf("t2_valid_%0d_%0d", s, c), 32'(bus.valid_o), 32'(exp_v));
                if (exp_v)
                    check_data($sformatf("t2_data_%0d", s), sample_t'(bus.data_o), e2[s / 4]);
            end
        end

        $display("[TB] overflow with ready low");
        fill_groups(8);
        check_num("t3_level_full", 32'(bus.level_o), 8);
        check_num("t3_no_overflow_yet", 32'(bus.overflow_o), 0);
        for (int j = 0; j < FACTOR; j++)
            apply_stimulus(1'b1, sample_t'(90), 1'b0);
        check_num("t3_level_after_drop", 32'(bus.level_o), 8);
        check_num("t3_overflow", 32'(bus.overflow_o), 1);
        bus.valid_i = 1'b0;
        bus.ready_i = 1'b1;
        for (int k = 0; k < 8; k++) begin
            check_num($sformatf("t3_drain_valid_%0d", k), 32'(bus.valid_o), 1);
            check_data($sformatf("t3_drain_data_%0d", k), sample_t'(bus.data_o), sample_t'(10 * (k + 1)));
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_num("t3_empty_valid", 32'(bus.valid_o), 0);
        check_num("t3_empty_level", 32'(bus.level_o), 0);
        check_num("t3_overflow_sticky", 32'(bus.overflow_o), 1);

        $display("[TB] full fifo with push and pop together");
        do_reset();
        check_num("t4_overflow_cleared", 32'(bus.overflow_o), 0);
        fill_groups(8);
        check_num("t4_level_full", 32'(bus.level_o), 8);
        for (int j = 0; j < FACTOR - 1; j++)
            apply_stimulus(1'b1, sample_t'(200), 1'b0);
        apply_stimulus(1'b1, sample_t'(200), 1'b1);
        check_num("t4_level_kept", 32'(bus.level_o), 8);
        check_num("t4_no_overflow", 32'(bus.overflow_o), 0);
        for (int k = 1; k < 8; k++) begin
            check_data($sformatf("t4_drain_%0d", k), sample_t'(bus.data_o), sample_t'(10 * (k + 1)));
            apply_stimulus(1'b0, '0, 1'b1);
        end
        check_data("t4_last_entry", sample_t'(bus.data_o), sample_t'(200));
        apply_stimulus(1'b0, '0, 1'b1);
        check_num("t4_empty", 32'(bus.valid_o), 0);

        $display("[TB] extreme values");
        for (int g = 0; g < 3; g++) begin
            for (int j = 0; j < FACTOR; j++)
                apply_stimulus(1'b1, g5[g][j], 1'b1);
            check_num($sformatf("t5_valid_%0d", g), 32'(bus.valid_o), 1);
            check_data($sformatf("t5_data_%0d", g), sample_t'(bus.data_o), e5[g]);
            apply_stimulus(1'b0, '0, 1'b1);
        end

        $display("[TB] reset in the middle of a group");
        fill_groups(3);
        apply_stimulus(1'b1, sample_t'(7), 1'b0);
        apply_stimulus(1'b1, sample_t'(7), 1'b0);
        check_num("t6_level_before", 32'(bus.level_o), 3);
        bus.valid_i = 1'b0;
        reset = 1'b0;
        #1;
        check_num("t6_valid_in_reset", 32'(bus.valid_o), 0);
        check_num("t6_data_in_reset", 32'(bus.data_o), 0);
        check_num("t6_level_in_reset", 32'(bus.level_o), 0);
        check_num("t6_overflow_in_reset", 32'(bus.overflow_o), 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        for (int j = 0; j < FACTOR - 1; j++) begin
            apply_stimulus(1'b1, sample_t'(50), 1'b1);
            check_num($sformatf("t6_no_emit_%0d", j), 32'(bus.valid_o), 0);
        end
        apply_stimulus(1'b1, sample_t'(50), 1'b1);
        check_num("t6_emit_valid", 32'(bus.valid_o), 1);
        check_data("t6_emit_data", sample_t'(bus.data_o), sample_t'(50));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
